// File: rtl/instrumented_adder_sequencer.sv
// Measurement initiator for the instrumented ripple adder: drives every adder control,
// runs 1..15 timed ring-oscillator measurements and returns one accumulated result.
module instrumented_adder_sequencer #(
    parameter int RESET_CYCLES   = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_MARGIN = 1024,
    parameter int ACC_W          = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    input  logic [31:0]      cfg_integration_time,
    input  logic [3:0]       cfg_repeats,
    input  logic             cfg_extra_inverter,
    input  logic             cfg_bypass,
    input  logic             cfg_control,
    input  logic [7:0]       cfg_a_ext_bit,
    input  logic [7:0]       cfg_a_ring_bit,
    input  logic [7:0]       cfg_s_output_bit,
    input  logic [7:0]       cfg_a,
    input  logic [7:0]       cfg_b,
    output logic             dut_reset,
    output logic             dut_stop_b,
    output logic             dut_extra_inverter,
    output logic             dut_bypass_b,
    output logic             dut_control_b,
    output logic             dut_counter_enable,
    output logic             dut_counter_load,
    output logic [7:0]       dut_a_input_ext_bit_b,
    output logic [7:0]       dut_a_input_ring_bit_b,
    output logic [7:0]       dut_s_output_bit_b,
    output logic [7:0]       dut_a_input,
    output logic [7:0]       dut_b_input,
    output logic [31:0]      dut_integration_time,
    input  logic [7:0]       dut_sum,
    input  logic             dut_done,
    input  logic [31:0]      dut_ring_count,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [ACC_W-1:0] result_acc,
    output logic [3:0]       result_runs,
    output logic [7:0]       result_sum,
    output logic             result_sum_err,
    output logic             result_timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_STOP, S_CAPTURE, S_RESULT
    } state_t;

    state_t state, state_nxt;

    logic [31:0] integ_q;
    logic [3:0]  target_q;
    logic        xinv_q, bypass_q, control_q;
    logic [7:0]  ext_bit_q, ring_bit_q, out_bit_q, a_q, b_q;
    logic [15:0] phase_cnt;
    logic [32:0] wd;

    logic        accept, wd_expired, last_run;
    logic [32:0] wd_limit;
    logic [7:0]  expect_sum;

    assign accept     = (state == S_IDLE) && start && !abort;
    assign wd_limit   = {1'b0, integ_q} + 33'(TIMEOUT_MARGIN);
    assign wd_expired = (wd == wd_limit);
    assign expect_sum = a_q + b_q;
    assign last_run   = ({1'b0, result_runs} + 5'd1) == {1'b0, target_q};

    // NOTE: every output gets its default first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt              = state;
        busy                   = (state != S_IDLE);
        result_valid           = 1'b0;
        dut_reset              = 1'b0;
        dut_stop_b             = 1'b0;
        dut_counter_enable     = 1'b0;
        dut_counter_load       = 1'b0;
        dut_extra_inverter     = 1'b0;
        dut_bypass_b           = 1'b1;
        dut_control_b          = 1'b1;
        dut_a_input_ext_bit_b  = 8'hFF;
        dut_a_input_ring_bit_b = 8'hFF;
        dut_s_output_bit_b     = 8'hFF;
        dut_a_input            = 8'h00;
        dut_b_input            = 8'h00;
        dut_integration_time   = 32'h0;

        if (state != S_IDLE) begin
            dut_extra_inverter     = xinv_q;
            dut_bypass_b           = ~bypass_q;
            dut_control_b          = ~control_q;
            dut_a_input_ext_bit_b  = ~ext_bit_q;
            dut_a_input_ring_bit_b = ~ring_bit_q;
            dut_s_output_bit_b     = ~out_bit_q;
            dut_a_input            = a_q;
            dut_b_input            = b_q;
            dut_integration_time   = integ_q;
        end

        case (state)
            S_IDLE:    if (accept) state_nxt = S_CLEAR;
            S_CLEAR: begin
                dut_reset = 1'b1;
                if (phase_cnt == 16'(RESET_CYCLES - 1)) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                dut_counter_load = 1'b1;
                state_nxt        = S_RUN;
            end
            S_RUN: begin
                dut_stop_b         = 1'b1;
                dut_counter_enable = 1'b1;
                if (dut_done || wd_expired) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (phase_cnt == 16'(SETTLE_CYCLES - 1))
                    state_nxt = result_timeout ? S_RESULT : S_CAPTURE;
            end
            S_CAPTURE: state_nxt = last_run ? S_RESULT : S_CLEAR;
            S_RESULT: begin
                result_valid = 1'b1;
                if (result_ready) state_nxt = S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase

        if ((state != S_IDLE) && abort) state_nxt = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            integ_q        <= '0;
            target_q       <= '0;
            xinv_q         <= 1'b0;
            bypass_q       <= 1'b0;
            control_q      <= 1'b0;
            ext_bit_q      <= '0;
            ring_bit_q     <= '0;
            out_bit_q      <= '0;
            a_q            <= '0;
            b_q            <= '0;
            phase_cnt      <= '0;
            wd             <= '0;
            result_acc     <= '0;
            result_runs    <= '0;
            result_sum     <= '0;
            result_sum_err <= 1'b0;
            result_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= (state_nxt != state) ? 16'h0 : phase_cnt + 16'h1;
            wd        <= (state == S_RUN) ? wd + 33'h1 : 33'h0;

            if (accept) begin
                integ_q        <= cfg_integration_time;
                target_q       <= (cfg_repeats == 4'd0) ? 4'd1 : cfg_repeats;
                xinv_q         <= cfg_extra_inverter;
                bypass_q       <= cfg_bypass;
                control_q      <= cfg_control;
                ext_bit_q      <= cfg_a_ext_bit;
                ring_bit_q     <= cfg_a_ring_bit;
                out_bit_q      <= cfg_s_output_bit;
                a_q            <= cfg_a;
                b_q            <= cfg_b;
                result_acc     <= '0;
                result_runs    <= '0;
                result_sum     <= '0;
                result_sum_err <= 1'b0;
                result_timeout <= 1'b0;
            end

            // An aborted measurement leaves the result registers exactly as they were.
            if (!abort) begin
                if (state == S_RUN && !dut_done && wd_expired)
                    result_timeout <= 1'b1;
                if (state == S_CAPTURE) begin
                    result_acc  <= result_acc + ACC_W'(dut_ring_count);
                    result_runs <= result_runs + 4'd1;
                    result_sum  <= dut_sum;
                    if (dut_sum != expect_sum) result_sum_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// Bench for instrumented_adder_sequencer: a behavioural adder model answers the sequencer,
// and results are predicted from per-run tables of ring counts and sums.
module tb_instrumented_adder_sequencer;

    localparam int RC    = 4;
    localparam int SC    = 8;
    localparam int TM    = 1024;
    localparam int ACC_W = 36;

    logic             clk = 1'b0;
    logic             reset, start, abort, busy;
    logic [31:0]      cfg_integration_time;
    logic [3:0]       cfg_repeats;
    logic             cfg_extra_inverter, cfg_bypass, cfg_control;
    logic [7:0]       cfg_a_ext_bit, cfg_a_ring_bit, cfg_s_output_bit, cfg_a, cfg_b;
    logic             dut_reset, dut_stop_b, dut_extra_inverter, dut_bypass_b, dut_control_b;
    logic             dut_counter_enable, dut_counter_load;
    logic [7:0]       dut_a_input_ext_bit_b, dut_a_input_ring_bit_b, dut_s_output_bit_b;
    logic [7:0]       dut_a_input, dut_b_input;
    logic [31:0]      dut_integration_time;
    logic [7:0]       dut_sum;
    logic             dut_done;
    logic [31:0]      dut_ring_count;
    logic             result_valid, result_ready;
    logic [ACC_W-1:0] result_acc;
    logic [3:0]       result_runs;
    logic [7:0]       result_sum;
    logic             result_sum_err, result_timeout;

    always #5 clk = ~clk;

    instrumented_adder_sequencer #(
        .RESET_CYCLES(RC), .SETTLE_CYCLES(SC), .TIMEOUT_MARGIN(TM), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy),
        .cfg_integration_time(cfg_integration_time), .cfg_repeats(cfg_repeats),
        .cfg_extra_inverter(cfg_extra_inverter), .cfg_bypass(cfg_bypass), .cfg_control(cfg_control),
        .cfg_a_ext_bit(cfg_a_ext_bit), .cfg_a_ring_bit(cfg_a_ring_bit),
        .cfg_s_output_bit(cfg_s_output_bit), .cfg_a(cfg_a), .cfg_b(cfg_b),
        .dut_reset(dut_reset), .dut_stop_b(dut_stop_b), .dut_extra_inverter(dut_extra_inverter),
        .dut_bypass_b(dut_bypass_b), .dut_control_b(dut_control_b),
        .dut_counter_enable(dut_counter_enable), .dut_counter_load(dut_counter_load),
        .dut_a_input_ext_bit_b(dut_a_input_ext_bit_b), .dut_a_input_ring_bit_b(dut_a_input_ring_bit_b),
        .dut_s_output_bit_b(dut_s_output_bit_b), .dut_a_input(dut_a_input), .dut_b_input(dut_b_input),
        .dut_integration_time(dut_integration_time), .dut_sum(dut_sum), .dut_done(dut_done),
        .dut_ring_count(dut_ring_count), .result_valid(result_valid), .result_ready(result_ready),
        .result_acc(result_acc), .result_runs(result_runs), .result_sum(result_sum),
        .result_sum_err(result_sum_err), .result_timeout(result_timeout)
    );

    // Adder model: run n (1-based) reports ring_tbl[n] and sum_tbl[n]; done after done_after enabled cycles.
    logic [31:0] ring_tbl [16];
    logic [7:0]  sum_tbl  [16];
    int          done_after = 0;
    bit          never_done = 1'b0;
    int          load_cnt = 0, en_cnt = 0;
    int          reset_pulses = 0, reset_cycles = 0, load_cycles = 0, run_cycles = 0;
    logic        prev_reset = 1'b0, stop_b_before_valid = 1'b0;

    assign dut_done       = !never_done && dut_counter_enable && (en_cnt >= done_after);
    assign dut_ring_count = ring_tbl[load_cnt[3:0]];
    assign dut_sum        = sum_tbl[load_cnt[3:0]];

    always @(posedge clk) begin
        prev_reset <= dut_reset;
        if (!busy) begin
            load_cnt <= 0; en_cnt <= 0;
            reset_pulses <= 0; reset_cycles <= 0; load_cycles <= 0; run_cycles <= 0;
        end else begin
            if (dut_counter_load) begin
                load_cnt    <= load_cnt + 1;
                en_cnt      <= 0;
                load_cycles <= load_cycles + 1;
            end else if (dut_counter_enable) begin
                en_cnt <= en_cnt + 1;
            end
            if (dut_reset && !prev_reset) reset_pulses <= reset_pulses + 1;
            if (dut_reset)                reset_cycles <= reset_cycles + 1;
            if (dut_counter_enable)       run_cycles   <= run_cycles + 1;
            if (!result_valid)            stop_b_before_valid <= dut_stop_b;
        end
    end

    int total = 0, bad = 0;
    logic [7:0]  e_a, e_b, e_ext, e_ring, e_out;
    logic        e_xi, e_by, e_ct;
    logic [31:0] e_integ;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_drive(input string tag);
        check({tag, "_ctl"}, {dut_reset, dut_stop_b, dut_extra_inverter, dut_bypass_b, dut_control_b,
                              dut_counter_enable, dut_counter_load, dut_a_input_ext_bit_b,
                              dut_a_input_ring_bit_b, dut_s_output_bit_b},
              {7'b0001100, 24'hFF_FFFF});
        check({tag, "_ops"}, {dut_a_input, dut_b_input, dut_integration_time}, 48'h0);
    endtask

    task automatic check_res(input string tag, input logic [63:0] acc, input logic [3:0] runs,
                             input logic [7:0] sum, input logic err, input logic to);
        check({tag, "_acc"}, 64'(result_acc), acc);
        check({tag, "_runs_sum_err_to"}, {result_runs, result_sum, result_sum_err, result_timeout},
              {runs, sum, err, to});
    endtask

    task automatic begin_meas(input logic [3:0] rep, input logic [7:0] a, input logic [7:0] b,
                              input logic [31:0] integ);
        @(negedge clk);
        e_a = a; e_b = b; e_integ = integ;
        e_xi = 1'($urandom); e_by = 1'($urandom); e_ct = 1'($urandom);
        e_ext = 8'($urandom); e_ring = 8'($urandom); e_out = 8'($urandom);
        cfg_repeats = rep; cfg_a = a; cfg_b = b; cfg_integration_time = integ;
        cfg_extra_inverter = e_xi; cfg_bypass = e_by; cfg_control = e_ct;
        cfg_a_ext_bit = e_ext; cfg_a_ring_bit = e_ring; cfg_s_output_bit = e_out;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("accept_busy_reset", {busy, dut_reset, result_valid}, 3'b110);
        cfg_repeats = ~rep; cfg_a = ~a; cfg_b = ~b; cfg_integration_time = ~integ;
        cfg_extra_inverter = ~e_xi; cfg_bypass = ~e_by; cfg_control = ~e_ct;
        cfg_a_ext_bit = ~e_ext; cfg_a_ring_bit = ~e_ring; cfg_s_output_bit = ~e_out;
        #1;
        check("latched_drive", {dut_extra_inverter, dut_bypass_b, dut_control_b, dut_a_input_ext_bit_b,
                                dut_a_input_ring_bit_b, dut_s_output_bit_b, dut_a_input, dut_b_input},
              {e_xi, ~e_by, ~e_ct, ~e_ext, ~e_ring, ~e_out, e_a, e_b});
        check("latched_integ", dut_integration_time, e_integ);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!result_valid && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("valid_within_budget", result_valid, 1'b1);
    endtask

    task automatic wait_run_phase();
        int n = 0;
        while (!dut_counter_enable && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_run", dut_counter_enable, 1'b1);
    endtask

    task automatic finish_result();
        @(negedge clk);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("handshake_idle", {busy, result_valid}, 2'b00);
    endtask

    function automatic logic [63:0] model_acc(input int eff);
        logic [63:0] s = 64'h0;
        for (int i = 1; i <= eff; i++) s += 64'(ring_tbl[i]);
        return s;
    endfunction

    function automatic logic model_err(input int eff, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] good = a + b;
        logic e = 1'b0;
        for (int i = 1; i <= eff; i++) if (sum_tbl[i] != good) e = 1'b1;
        return e;
    endfunction

    initial begin
        int lat, eff;
        logic [3:0] rep;
        logic [7:0] ra, rb;
        logic [63:0] hold_acc;

        for (int i = 0; i < 16; i++) begin ring_tbl[i] = 32'h0; sum_tbl[i] = 8'h0; end
        reset = 1'b1; start = 1'b0; abort = 1'b0; result_ready = 1'b0;
        cfg_integration_time = '0; cfg_repeats = '0; cfg_extra_inverter = 1'b0; cfg_bypass = 1'b0;
        cfg_control = 1'b0; cfg_a_ext_bit = '0; cfg_a_ring_bit = '0; cfg_s_output_bit = '0;
        cfg_a = '0; cfg_b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy_valid", {busy, result_valid}, 2'b00);
        check_idle_drive("reset_idle");
        check_res("reset", 64'h0, 4'd0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;

        // Single run, done after 100 enabled cycles.
        ring_tbl[1] = 32'd5000; sum_tbl[1] = 8'd7; done_after = 100;
        begin_meas(4'd1, 8'd3, 8'd4, 32'd100);
        wait_valid(lat);
        check("t1_latency", lat, 1 + RC + 1 + (done_after + 1) + SC + 1);
        check("t1_load_cycles", load_cycles, 1);
        check_res("t1", 64'd5000, 4'd1, 8'd7, 1'b0, 1'b0);
        finish_result();
        check_idle_drive("t1_idle");

        // Four runs, counts 10..40.
        for (int i = 1; i <= 4; i++) begin ring_tbl[i] = 32'(10 * i); sum_tbl[i] = 8'd7; end
        done_after = $urandom_range(5, 20);
        begin_meas(4'd4, 8'd3, 8'd4, 32'd20);
        wait_valid(lat);
        check("t2_latency", lat, 4 * (RC + 1 + (done_after + 1) + SC + 1) + 1);
        check("t2_reset_pulses", reset_pulses, 4);
        check("t2_reset_cycles", reset_cycles, 4 * RC);
        check_res("t2", 64'd100, 4'd4, 8'd7, 1'b0, 1'b0);
        finish_result();

        // Watchdog timeout: nothing is counted.
        never_done = 1'b1;
        begin_meas(4'd2, 8'd3, 8'd4, 32'd50);
        wait_valid(lat);
        check("t3_run_cycles", (run_cycles == 50 + TM) || (run_cycles == 50 + TM + 1), 1'b1);
        check("t3_stopped_before_valid", stop_b_before_valid, 1'b0);
        check_res("t3", 64'h0, 4'd0, 8'h00, 1'b0, 1'b1);
        finish_result();
        never_done = 1'b0;

        // Sum mismatch on run 2 of 3 is sticky; last captured sum reported.
        for (int i = 1; i <= 3; i++) ring_tbl[i] = $urandom;
        sum_tbl[1] = 8'h01; sum_tbl[2] = 8'h02; sum_tbl[3] = 8'h01; done_after = 3;
        begin_meas(4'd3, 8'hFF, 8'h02, 32'd3);
        wait_valid(lat);
        check_res("t4", model_acc(3), 4'd3, 8'h01, 1'b1, 1'b0);
        finish_result();

        // Abort in RUN.
        done_after = 200;
        begin_meas(4'd1, 8'd5, 8'd6, 32'd200);
        wait_run_phase();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5a_busy_valid", {busy, result_valid}, 2'b00);
        check_idle_drive("t5a_idle");
        check_res("t5a", 64'h0, 4'd0, 8'h00, 1'b0, 1'b0);

        // Abort in RESULT with result_ready low.
        ring_tbl[1] = 32'hDEAD_BEEF; sum_tbl[1] = 8'd11; done_after = 2;
        begin_meas(4'd1, 8'd5, 8'd6, 32'd2);
        wait_valid(lat);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5b_busy_valid", {busy, result_valid}, 2'b00);
        check_idle_drive("t5b_idle");
        check_res("t5b_kept", 64'hDEAD_BEEF, 4'd1, 8'd11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("t5b_valid_stays_low", result_valid, 1'b0);

        // Backpressure: result held for 20 cycles, starts ignored.
        ring_tbl[1] = 32'd77; ring_tbl[2] = 32'd88; sum_tbl[1] = 8'd30; sum_tbl[2] = 8'd30;
        done_after = 1;
        begin_meas(4'd2, 8'd10, 8'd20, 32'd1);
        wait_valid(lat);
        for (int i = 0; i < 20; i++) begin
            start = 1'($urandom);
            @(negedge clk);
            check("t6_hold", {result_valid, 64'(result_acc), result_runs, result_sum, result_sum_err,
                              result_timeout}, {1'b1, 64'd165, 4'd2, 8'd30, 1'b0, 1'b0});
        end
        start = 1'b0;
        finish_result();
        repeat (2) @(negedge clk);
        check_res("t6_idle_keep", 64'd165, 4'd2, 8'd30, 1'b0, 1'b0);

        // Synchronous reset while the result is pending.
        begin_meas(4'd1, 8'd10, 8'd20, 32'd1);
        wait_valid(lat);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t7_busy_valid", {busy, result_valid}, 2'b00);
        check_idle_drive("t7_idle");
        check_res("t7", 64'h0, 4'd0, 8'h00, 1'b0, 1'b0);

        // Randomized measurements; repeats of 0 behave as 1.
        for (int it = 0; it < 6; it++) begin
            rep = 4'($urandom_range(0, 15));
            if (it == 0) rep = 4'd0;
            eff = (rep == 4'd0) ? 1 : int'(rep);
            ra = 8'($urandom); rb = 8'($urandom);
            done_after = $urandom_range(0, 30);
            for (int i = 1; i <= 15; i++) begin
                ring_tbl[i] = $urandom;
                sum_tbl[i]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ra + rb;
            end
            begin_meas(rep, ra, rb, $urandom);
            wait_valid(lat);
            check("rand_latency", lat, eff * (RC + 1 + (done_after + 1) + SC + 1) + 1);
            check_res("rand", model_acc(eff), 4'(eff), sum_tbl[eff], model_err(eff, ra, rb), 1'b0);
            hold_acc = model_acc(eff);
            finish_result();
            check("rand_idle_acc", 64'(result_acc), hold_acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instrumented_adder_sequencer.md
Name: instrumented_adder_sequencer

Overview:
On-chip measurement initiator for the instrumented ripple adder. It drives every control input the adder otherwise receives from the logic analyser: counter reset, load, enable, ring stop, path selects and adder operands. It runs 1..15 timed ring-oscillator measurements, accumulates the ring counts, checks the adder sum, and returns a single result through a valid/ready handshake. It sits between a CPU-facing register block and the adder instance, in the clk domain.

Parameters:
RESET_CYCLES, 4, cycles dut_reset is held high before each run (min 1)
SETTLE_CYCLES, 8, cycles waited after stopping the ring before capture (min 1)
TIMEOUT_MARGIN, 1024, cycles allowed in RUN beyond cfg_integration_time before declaring timeout
ACC_W, 36, accumulator width; holds 15 x 2^32-1 without overflow

Ports:
clk  in  1  system clock; also clocks the adder's time counter
reset  in  1  synchronous, active-high
start  in  1  request measurement; accepted only in IDLE
abort  in  1  cancel measurement; return to IDLE, no result
busy  out  1  high in every state except IDLE
cfg_integration_time  in  32  cycles per run, passed to the adder
cfg_repeats  in  4  runs per measurement; 0 is treated as 1
cfg_extra_inverter, cfg_bypass, cfg_control  in  1 each  active-high path options
cfg_a_ext_bit, cfg_a_ring_bit, cfg_s_output_bit  in  8 each  active-high bit selects
cfg_a, cfg_b  in  8 each  adder operands
dut_reset, dut_stop_b, dut_extra_inverter, dut_bypass_b, dut_control_b, dut_counter_enable, dut_counter_load  out  1 each  to adder
dut_a_input_ext_bit_b, dut_a_input_ring_bit_b, dut_s_output_bit_b, dut_a_input, dut_b_input  out  8 each  to adder
dut_integration_time  out  32  to adder
dut_sum  in  8  adder sum_out
dut_done  in  1  adder integration counter reached zero
dut_ring_count  in  32  adder ring_osc_counter_out
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_acc  out  ACC_W  sum of ring counts over completed runs
result_runs  out  4  runs completed
result_sum  out  8  dut_sum captured in the last run
result_sum_err  out  1  any run had dut_sum != (cfg_a+cfg_b) mod 256
result_timeout  out  1  the measurement ended by watchdog

Behaviour:
- Reset and IDLE output values: FSM=IDLE, busy=0, result_valid=0, all result_* = 0.
- Idle drive values: dut_reset=0, dut_stop_b=0 (ring stopped), dut_counter_enable=0, dut_counter_load=0, dut_bypass_b=1, dut_control_b=1, dut_extra_inverter=0, all *_bit_b buses=8'hFF, operands=0, dut_integration_time=0.
- Start is accepted when start=1 in IDLE and abort=0. On the accepting edge, all cfg_* are latched. The run count is effective = max(cfg_repeats,1). The accumulator, run counter and error flags clear.
- While busy, static dut outputs come from the latched config. Active-high cfg values are inverted onto the *_b outputs.
- The FSM has seven states:
  - CLEAR: dut_reset=1 for RESET_CYCLES cycles, then LOAD.
  - LOAD: dut_counter_load=1 for exactly one cycle, then RUN.
  - RUN: dut_stop_b=1, dut_counter_enable=1, watchdog counting from 0.
    - dut_done=1 goes to STOP.
    - Otherwise, watchdog == cfg_integration_time + TIMEOUT_MARGIN (33-bit compare) sets the timeout flag and goes to STOP.
    - If done and timeout occur in the same cycle, done wins.
  - STOP: dut_stop_b=0, dut_counter_enable=0 for SETTLE_CYCLES cycles. Timeout goes to RESULT; otherwise CAPTURE.
  - CAPTURE: one cycle.
    - acc += dut_ring_count (zero-extended); runs++; result_sum <= dut_sum.
    - A sum mismatch sets sum_err (sticky within the measurement).
    - If runs == effective count, go to RESULT; else go to CLEAR.
  - RESULT: result_valid=1 with all result_* stable. Exit to IDLE on the cycle where result_valid && result_ready. result_* keep their values in IDLE until the next accepted start.
- A timed-out run is not accumulated and not counted.
- abort=1 in any busy state: next state IDLE, result_valid stays 0, idle drive values resume next cycle, result_* unchanged.
- abort during RESULT discards the result.
- A start that arrives while busy is ignored.
- Synchronous reset mid-run: IDLE next cycle, with all outputs at reset values.
- Latency for one run with an immediate done: 1 (accept) + RESET_CYCLES + 1 + T_run + SETTLE_CYCLES + 1 cycles to result_valid.

Test Plan:
1. Model adder with done after 100 cycles, ring count 5000; cfg_repeats=1, a=3, b=4, sum=7 -> result_valid, acc=5000, runs=1, sum=7, sum_err=0, timeout=0; dut_counter_load high exactly 1 cycle.
2. cfg_repeats=4, ring counts 10,20,30,40 -> acc=100, runs=4; dut_reset pulsed 4 times, each pulse RESET_CYCLES long.
3. Model never asserts done, integration_time=50 -> timeout after 1074 RUN cycles, runs=0, acc=0, timeout=1, dut_stop_b=0 before result_valid.
4. a=8'hFF, b=8'h02, model returns sum=8'h02 on run 2 of 3, else 8'h01 -> sum_err=1, result_sum=8'h01.
5. abort asserted in RUN, then separately in RESULT with result_ready=0 -> IDLE next cycle, result_valid never/no longer high, dut_stop_b=0, all *_bit_b=8'hFF.
6. result_ready held low 20 cycles -> result_valid and result_* stable; start pulses meanwhile are ignored; ready=1 -> IDLE, busy=0 next cycle.
